// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with transmit FIFO and baud divider.
// Optional line break generation is enabled with `define UART_TX_BREAK_EN.
module uart_tx_fifo #(
  parameter int BITS         = 8,
  parameter int STOPBITS     = 1,
  parameter int PARITY       = 2,
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_ready,
  input  logic [BITS-1:0]          data,
`ifdef UART_TX_BREAK_EN
  input  logic                     break_req,
`endif
  output logic                     data_accept,
  output logic                     tx,
  output logic                     busy,
  output logic                     data_sent,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(BITS);
  localparam logic [CW-1:0] BAUD_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(BITS - 1);
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MAB} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`endif

  state_t          r_state;
  logic [BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [CW-1:0]   r_baud;
  logic [IW-1:0]   r_bit_idx;
  logic [BITS-1:0] r_shift;
  logic            r_par;
  logic            r_stop_idx;
  logic            r_tx;
  logic            r_data_sent;

  logic            w_push;
  logic            w_pop;
  logic            w_baud_zero;
  logic            w_frame_end;
  logic            w_resume;
  logic [BITS-1:0] w_head;

  assign w_baud_zero = (r_baud == '0);
  assign w_frame_end = (r_state == S_STOP) && w_baud_zero && (r_stop_idx == 1'(STOPBITS - 1));
  assign w_head      = r_mem[r_rd_ptr];

  // Pop points: idle with data waiting, or back-to-back at the end of a frame.
`ifdef UART_TX_BREAK_EN
  assign w_resume = ((r_state == S_IDLE) && !break_req) || ((r_state == S_MAB) && w_baud_zero);
`else
  assign w_resume = (r_state == S_IDLE);
`endif
  assign w_pop  = (r_count != '0) && (w_resume || w_frame_end);
  assign w_push = data_ready && data_accept;

  assign data_accept = (r_count != FULL);
  assign fifo_count  = r_count;
  assign tx          = r_tx;
  assign data_sent   = r_data_sent;
  assign busy        = (r_state != S_IDLE) || (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_baud      <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_stop_idx  <= 1'b0;
      r_tx        <= 1'b1;
      r_data_sent <= 1'b0;
    end else begin
      r_data_sent <= 1'b0;
      if (r_state != S_IDLE) begin
        r_baud <= w_baud_zero ? BAUD_LOAD : r_baud - CW'(1);
      end
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
`ifdef UART_TX_BREAK_EN
          if (break_req) begin
            r_state <= S_BREAK;
            r_tx    <= 1'b0;
          end
`endif
        end
        S_START: begin
          if (w_baud_zero) begin
            r_state   <= S_DATA;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_baud_zero) begin
            if (r_bit_idx == LAST_BIT) begin
              if (PARITY != 0) begin
                r_state <= S_PARITY;
                r_tx    <= r_par;
              end else begin
                r_state    <= S_STOP;
                r_stop_idx <= 1'b0;
                r_tx       <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + IW'(1);
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end
        end
        S_PARITY: begin
          if (w_baud_zero) begin
            r_state    <= S_STOP;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_frame_end) begin
            r_data_sent <= 1'b1;
            r_state     <= S_IDLE;
            r_tx        <= 1'b1;
          end else if (w_baud_zero) begin
            r_stop_idx <= 1'b1;
          end
        end
`ifdef UART_TX_BREAK_EN
        S_BREAK: begin
          r_tx <= 1'b0;
          if (!break_req) begin
            r_state <= S_MAB;
            r_tx    <= 1'b1;
            r_baud  <= BAUD_LOAD;
          end
        end
        S_MAB: begin
          if (w_baud_zero) begin
            r_state <= S_IDLE;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
      // A pop always starts a new frame, overriding whatever the state did above.
      if (w_pop) begin
        r_state    <= S_START;
        r_tx       <= 1'b0;
        r_baud     <= BAUD_LOAD;
        r_shift    <= w_head;
        r_par      <= (PARITY == 1) ? ~^w_head : ^w_head;
        r_stop_idx <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int FRAME = 44;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data_ready = 1'b0;
  logic       v_ready = 1'b0;
  logic [7:0] data = 8'h00;
`ifdef UART_TX_BREAK_EN
  logic       break_req = 1'b0;
`endif

  logic data_accept, tx, busy, data_sent;
  logic [2:0] fifo_count;
  logic odd_acc, odd_tx, odd_busy, odd_ds;
  logic [2:0] odd_cnt;
  logic nop_acc, nop_tx, nop_busy, nop_ds;
  logic [2:0] nop_cnt;
  logic s2_acc, s2_tx, s2_busy, s2_ds;
  logic [2:0] s2_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int start_q[$];
  int ds_q[$];
  int mon_frames = 0;
  bit mon_en = 1'b1;
  bit mon_abort;
  logic [10:0] mon_bits;
  logic [7:0] mon_exp;

  int t_push, o, n, lows, base_s;
  int ds_main, ds_odd, ds_nop, ds_s2, ds_main_n;
  logic last_busy;
  logic [63:0] tr_main, tr_odd, tr_nop, tr_s2;

  uart_tx_fifo #(.BITS(8), .STOPBITS(1), .PARITY(2), .CLKS_PER_BIT(CPB), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .data_ready(data_ready), .data(data),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .data_accept(data_accept), .tx(tx), .busy(busy), .data_sent(data_sent), .fifo_count(fifo_count));

  uart_tx_fifo #(.BITS(8), .STOPBITS(1), .PARITY(1), .CLKS_PER_BIT(CPB), .DEPTH(4)) u_odd (
    .clk(clk), .rst(rst), .data_ready(v_ready), .data(data),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .data_accept(odd_acc), .tx(odd_tx), .busy(odd_busy), .data_sent(odd_ds), .fifo_count(odd_cnt));

  uart_tx_fifo #(.BITS(8), .STOPBITS(1), .PARITY(0), .CLKS_PER_BIT(CPB), .DEPTH(4)) u_nop (
    .clk(clk), .rst(rst), .data_ready(v_ready), .data(data),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .data_accept(nop_acc), .tx(nop_tx), .busy(nop_busy), .data_sent(nop_ds), .fifo_count(nop_cnt));

  uart_tx_fifo #(.BITS(8), .STOPBITS(2), .PARITY(2), .CLKS_PER_BIT(CPB), .DEPTH(4)) u_s2 (
    .clk(clk), .rst(rst), .data_ready(v_ready), .data(data),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .data_accept(s2_acc), .tx(s2_tx), .busy(s2_busy), .data_sent(s2_ds), .fifo_count(s2_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] b, input bit accepted);
    data = b;
    data_ready = 1'b1;
    if (accepted) exp_q.push_back(b);
    @(negedge clk);
    data_ready = 1'b0;
    data = ~b;
  endtask

  function automatic logic [63:0] expand(input logic [15:0] pat, input int nbits);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < nbits * CPB; i++) r[i] = pat[i / CPB];
    return r;
  endfunction

  // Frame decoder: samples one cycle into each bit period after a falling edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en && rst && !tx) begin
        start_q.push_back(cyc);
        mon_abort = 1'b0;
        mon_bits = '0;
        for (int k = 1; k < FRAME; k++) begin
          @(negedge clk);
          if (!rst) mon_abort = 1'b1;
          if (k % CPB == 1) mon_bits[k / CPB] = tx;
        end
        if (!mon_abort) begin
          mon_frames++;
          chk("frame_expected", 64'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            chk("frame_bits", mon_bits, {1'b1, ^mon_exp, mon_exp, 1'b0});
          end
        end
      end
    end
  end

  always @(negedge clk) if (rst && data_sent) ds_q.push_back(cyc);

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_data_sent", data_sent, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_data_accept", data_accept, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single 0x57 frame into all four parameter variants.
    tr_main = '0; tr_odd = '0; tr_nop = '0; tr_s2 = '0;
    ds_main = -1; ds_odd = -1; ds_nop = -1; ds_s2 = -1; ds_main_n = 0;
    data = 8'h57; data_ready = 1'b1; v_ready = 1'b1;
    exp_q.push_back(8'h57);
    @(negedge clk);
    data_ready = 1'b0; v_ready = 1'b0; data = 8'hA8;
    t_push = cyc;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      o = cyc - t_push - 1;
      if (o >= 0 && o < 64) begin
        tr_main[o] = tx; tr_odd[o] = odd_tx; tr_nop[o] = nop_tx; tr_s2[o] = s2_tx;
        if (data_sent) ds_main_n++;
        if (data_sent && ds_main < 0) ds_main = o;
        if (odd_ds && ds_odd < 0) ds_odd = o;
        if (nop_ds && ds_nop < 0) ds_nop = o;
        if (s2_ds && ds_s2 < 0) ds_s2 = o;
      end
    end
    chk("start_seen", start_q.size(), 1);
    if (start_q.size() > 0) chk("push_to_start_latency", start_q[0] - t_push, 1);
    chk("tx_even_pattern", tr_main[43:0], expand(16'b11010101110, 11));
    chk("tx_odd_pattern", tr_odd[43:0], expand(16'b10010101110, 11));
    chk("tx_nopar_pattern", tr_nop[39:0], expand(16'b1010101110, 10));
    chk("tx_stop2_pattern", tr_s2[47:0], expand(16'b111010101110, 12));
    chk("sent_offset_even", ds_main, 44);
    chk("sent_count_even", ds_main_n, 1);
    chk("sent_offset_odd", ds_odd, 44);
    chk("sent_offset_nopar", ds_nop, 40);
    chk("sent_offset_stop2", ds_s2, 48);

    // Burst of six pushes into a 4-deep FIFO.
    base_s = start_q.size();
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) chk("accept_low_when_full", data_accept, 0);
      push(8'(i), i <= 5);
    end
    chk("count_after_burst", fifo_count, 4);
    n = 0; last_busy = 1'b0;
    for (int i = 0; i < 5 * FRAME + 20 && n < 5; i++) begin
      last_busy = busy;
      @(negedge clk);
      if (data_sent) n++;
    end
    chk("burst_sent_pulses", n, 5);
    chk("busy_before_last_sent", last_busy, 1);
    chk("busy_after_last_sent", busy, 0);
    chk("burst_frames", start_q.size() - base_s, 5);
    for (int k = 0; k < 4; k++)
      if (start_q.size() > base_s + k + 1)
        chk("burst_start_gap", start_q[base_s + k + 1] - start_q[base_s + k], FRAME);

    // Push on the very edge a frame ends with two bytes queued.
    repeat (3) @(negedge clk);
    push(8'hA5, 1); push(8'h3C, 1); push(8'hC3, 1);
    chk("count_two_queued", fifo_count, 2);
    repeat (42) @(negedge clk);
    chk("count_before_frame_end", fifo_count, 2);
    push(8'h96, 1);
    chk("count_simul_push_pop", fifo_count, 2);
    chk("sent_on_simul_edge", data_sent, 1);
    chk("start_on_simul_edge", tx, 0);
    n = 0;
    for (int i = 0; i < 3 * FRAME + 20 && n < 3; i++) begin
      @(negedge clk);
      if (data_sent) n++;
    end
    chk("simul_tail_sent", n, 3);

    // Asynchronous reset while data bit 3 (a zero) is on the line.
    repeat (3) @(negedge clk);
    push(8'hA5, 1); push(8'h11, 1);
    repeat (17) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_count", fifo_count, 0);
    chk("async_rst_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    chk("quiet_after_reset", lows, 0);
    push(8'h33, 1);
    n = 0;
    for (int i = 0; i < FRAME + 20 && n < 1; i++) begin
      @(negedge clk);
      if (data_sent) n++;
    end
    chk("post_reset_sent", n, 1);
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

`ifdef UART_TX_BREAK_EN
    mon_en = 1'b0;
    push(8'h57, 0);
    repeat (10) @(negedge clk);
    break_req = 1'b1;
    n = 0;
    for (int i = 0; i < FRAME + 20 && n < 1; i++) begin
      @(negedge clk);
      if (data_sent) n++;
    end
    chk("brk_frame_completes", n, 1);
    repeat (3) @(negedge clk);
    chk("brk_tx_low", tx, 0);
    chk("brk_busy", busy, 1);
    push(8'h22, 0);
    chk("brk_push_queued", fifo_count, 1);
    repeat (2) @(negedge clk);
    chk("brk_tx_held", tx, 0);
    break_req = 1'b0;
    lows = 0;
    for (int i = 0; i < CPB; i++) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    chk("mab_high", lows, 0);
    @(negedge clk);
    chk("mab_then_start", tx, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with a built-in transmit FIFO, a clock-divider baud generator, selectable data width, parity mode and stop-bit count. It is the successor to the single-byte UART transmitter. The host pushes bytes with a valid/accept handshake, and the block serialises them back-to-back on tx without host pacing. It sits between a register/bus interface and the board-level TX pin.

Parameters:
BITS, 8, data bits per frame; legal range 5..9.
STOPBITS, 1, stop bits per frame; 1 or 2.
PARITY, 2, parity mode: 0 none, 1 odd, 2 even.
CLKS_PER_BIT, 16, clk cycles per bit period; must be >= 2.
DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  asynchronous, active-low reset.
data_ready  input  1  push strobe; data is written on a clk edge where data_ready=1 and data_accept=1.
data  input  BITS  byte to transmit.
data_accept  output  1  FIFO not full (combinational from the count register).
tx  output  1  serial line, idle high, registered.
busy  output  1  high while a frame is on the line or the FIFO is non-empty.
data_sent  output  1  one-cycle pulse at the end of each frame's final stop bit.
fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous): tx=1, busy=0, data_sent=0, fifo_count=0, data_accept=1, FSM=IDLE, pointers=0, baud counter=0. Reset mid-frame aborts the frame immediately and discards FIFO contents.
- FIFO: circular buffer with wrapping rd/wr pointers.
  - A push while full (data_accept=0) is ignored. Stored data is not corrupted and the count does not change.
  - A push and a pop on the same edge leave fifo_count unchanged.
  - A push is refused when full even if a pop occurs on the same edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. On an edge where the FIFO is non-empty, pop the head into the shift register, load the baud counter with CLKS_PER_BIT-1, and go to START with tx=0.
  - START -> DATA, DATA -> PARITY (or STOP when PARITY=0), PARITY -> STOP. Each transition occurs on the edge where the baud counter reaches 0; the counter then reloads CLKS_PER_BIT-1.
  - DATA: sends BITS bits, LSB first, with a bit index counting 0..BITS-1.
  - PARITY: even parity = XOR of the data bits; odd parity = its inverse.
  - STOP: tx=1 for STOPBITS bit periods. At its final expiry, data_sent pulses for one cycle. If the FIFO is non-empty, the FSM pops and enters START on that same edge, giving no idle gap. Otherwise it returns to IDLE.
- Latency: with the FSM idle and the FIFO empty, a push on edge N causes a pop on edge N+1, so tx falls at edge N+1.
- Frame length: (1 + BITS + (PARITY!=0) + STOPBITS) x CLKS_PER_BIT cycles exactly.
- Data width: data is captured at push time. Later changes to data do not affect queued bytes.
- busy = (state != IDLE) || (fifo_count != 0).

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined:
  - Adds input break_req (1 bit).
  - If break_req=1 while in IDLE, the FSM enters BREAK: tx=0, pops are suspended, and the FIFO still accepts pushes.
  - If break_req is asserted mid-frame, the current frame completes first.
  - When break_req is deasserted, tx=1 is held for one full bit period (mark-after-break) before IDLE resumes normal popping.
  - busy=1 in BREAK.
- Not defined: the port, the BREAK state and the associated logic are absent. Behaviour is exactly as described above.

Test Plan:
- Default params (BITS=8, PARITY=2, STOPBITS=1) with CLKS_PER_BIT=4: push 0x57 -> tx pattern 0, 1,1,1,0,1,0,1,0, parity 1, stop 1, each bit lasting 4 cycles. The frame is 44 cycles, and data_sent pulses once at cycle 44.
- PARITY=1 with 0x57 -> parity bit 0. PARITY=0 -> frame of 40 cycles, no parity bit. STOPBITS=2 -> tx high for 8 cycles before data_sent.
- DEPTH=4, idle start: push 6 bytes (0x01..0x06) on consecutive cycles:
  - 0x01..0x05 are accepted; data_accept=0 on the 6th cycle, so 0x06 is dropped.
  - Five frames are sent back-to-back with no idle cycles between stop and start.
  - data_sent pulses 5 times; busy falls after the last pulse.
- Simultaneous push/pop: with fifo_count=2, push on the edge a frame ends -> fifo_count stays 2 and the next start bit begins on that edge.
- Reset mid-frame: drive rst=0 during the DATA bit 3 period -> tx=1 asynchronously, fifo_count=0, busy=0. After release, there is no further tx activity until a new push.
- UART_TX_BREAK_EN defined:
  - Assert break_req mid-frame -> the frame completes, then tx=0 while break_req is held.
  - Deassert -> tx=1 for 4 cycles, then any queued byte starts.
